nibble_serial_add_ctrl: RTL

Sequencer that performs a WIDTH-bit addition by time-sharing a single `four_bit_FA` slice (port order a, b, c_in, sum, c_out), one nibble per clock, least-significant nibble first. It captures operands on a start strobe, runs the carry chain through a registered carry between cycles, and reports the result with a one-cycle `done` pulse. It sits between operand-producing logic and any consumer that needs wide sums at low area cost.

---
 rtl/nibble_serial_add_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - WIDTH-bit adder time-sharing one 4-bit full-adder slice, LS nibble first
// Optional signed-overflow output guarded by `NIBBLE_ADD_OVF_EN.

module four_bit_FA (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);
  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};
endmodule

module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef NIBBLE_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic             cy;
  logic [IDXW-1:0]  idx;

  logic [3:0] nib_a;
  logic [3:0] nib_b;
  logic [3:0] fa_sum;
  logic       fa_cout;

  // Nibble mux feeding the shared slice.
  always_comb begin
    nib_a = 4'h0;
    nib_b = 4'h0;
    for (int i = 0; i < NIB; i++) begin
      if (idx == IDXW'(i)) begin
        nib_a = ra[4*i +: 4];
        nib_b = rb[4*i +: 4];
      end
    end
  end

  four_bit_FA u_slice (
    .a     (nib_a),
    .b     (nib_b),
    .c_in  (cy),
    .sum   (fa_sum),
    .c_out (fa_cout)
  );

  wire accept = start && ((state == S_IDLE) || (state == S_DONE));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ra    <= '0;
      rb    <= '0;
      cy    <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          for (int i = 0; i < NIB; i++) begin
            if (idx == IDXW'(i)) sum[4*i +: 4] <= fa_sum;
          end
          cy  <= fa_cout;
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            c_out <= fa_cout;
            state <= S_DONE;
          end
        end
        default: begin
          if (accept) begin
            ra    <= a;
            rb    <= b;
            cy    <= c_in;
            idx   <= '0;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

`ifdef NIBBLE_ADD_OVF_EN
  // Carry into the MSB is ra^rb^sum at that bit; XOR with the final carry gives signed overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (state == S_RUN && idx == LAST_IDX) begin
      ovf <= ra[WIDTH-1] ^ rb[WIDTH-1] ^ fa_sum[3] ^ fa_cout;
    end
  end
`endif

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule
